// File: rtl/vram_pkg.sv
// Shared widths, blanking value and address packing for the VRAM arbiter slice.
package vram_pkg;
  localparam int ADDR_W = 19;
  localparam int PIX_W = 12;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam logic [PIX_W-1:0] BLANK_PIX = 12'h000;
  localparam int RD_LATENCY = 3;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO buffering renderer writes; power-of-two depth, pointers wrap naturally.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_W + PIX_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads always win, buffered renderer writes drain in idle cycles.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STALL_W = 16
) (
  input  logic               vga_clk,
  input  logic               rst,
  input  logic               rdn,
  input  logic [8:0]         row_addr,
  input  logic [9:0]         col_addr,
  output logic [11:0]        pix_data,
  input  logic               wr_valid,
  input  logic [18:0]        wr_addr,
  input  logic [11:0]        wr_data,
  output logic               wr_ready,
  output logic [18:0]        mem_addr,
  output logic               mem_we,
  output logic [11:0]        mem_wdata,
  input  logic [11:0]        mem_rdata,
  output logic [2:0]         fifo_level,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int WORD_W = ADDR_W + PIX_W;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0]     head;
  logic [LVL_W-1:0]      level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  rd_req;
  logic [RD_LATENCY-2:0] rd_v;

  // Renderer handshake: a write transfers on the edge where wr_valid && wr_ready;
  // wr_ready depends only on occupancy (never on wr_valid) and is low during reset.
  assign wr_ready   = !rst && !full;
  assign push       = wr_valid && wr_ready;
  assign rd_req     = !rdn;
  assign pop        = rdn && !empty;
  assign fifo_level = 3'(level);

  vram_wr_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(WORD_W)
  ) u_fifo (
    .clk      (vga_clk),
    .rst      (rst),
    .push     (push),
    .push_data({wr_addr, wr_data}),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rd_v      <= '0;
      pix_data  <= BLANK_PIX;
      stall_cnt <= '0;
    end else begin
      // rd_v tracks a read from address issue through the VRAM's one-cycle data latency.
      rd_v     <= {rd_v[RD_LATENCY-3:0], rd_req};
      pix_data <= rd_v[RD_LATENCY-2] ? mem_rdata : BLANK_PIX;

      if (rd_req) begin
        mem_addr <= pack_addr(row_addr, col_addr);
        mem_we   <= 1'b0;
      end else if (!empty) begin
        mem_addr  <= head[WORD_W-1:PIX_W];
        mem_wdata <= head[PIX_W-1:0];
        mem_we    <= 1'b1;
      end else begin
        mem_we <= 1'b0;
      end

      if (rd_req && !empty && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a queue scoreboard for VRAM writes and display pixels.
module tb_vram_arbiter;

  logic        vga_clk;
  logic        rst;
  logic        rdn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [11:0] pix_data;
  logic        wr_valid;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [2:0]  fifo_level;
  logic [15:0] stall_cnt;

  logic        rst_s;
  logic [11:0] pix_s;
  logic        wr_ready_s;
  logic [18:0] mem_addr_s;
  logic        mem_we_s;
  logic [11:0] mem_wdata_s;
  logic [2:0]  level_s;
  logic [3:0]  stall_s;

  int n_chk = 0;
  int n_fail = 0;
  logic [30:0] exp_wr_q[$];
  logic [11:0] exp_rd_q[$];

  vram_arbiter #(.FIFO_DEPTH(4), .STALL_W(16)) dut (
    .vga_clk(vga_clk), .rst(rst), .rdn(rdn), .row_addr(row_addr), .col_addr(col_addr),
    .pix_data(pix_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few cycles.
  vram_arbiter #(.FIFO_DEPTH(4), .STALL_W(4)) dut_s (
    .vga_clk(vga_clk), .rst(rst_s), .rdn(1'b0), .row_addr(9'd0), .col_addr(10'd0),
    .pix_data(pix_s), .wr_valid(1'b1), .wr_addr(19'h00077), .wr_data(12'h777),
    .wr_ready(wr_ready_s), .mem_addr(mem_addr_s), .mem_we(mem_we_s), .mem_wdata(mem_wdata_s),
    .mem_rdata(12'h000), .fifo_level(level_s), .stall_cnt(stall_s)
  );

  // clock / reset
  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  // VRAM model: synchronous read returning the low address bits
  always @(posedge vga_clk) mem_rdata <= mem_addr[11:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
  endtask

  // driver: hold a write until accepted; called and returns at a negedge
  task automatic push_wr(input logic [18:0] a, input logic [11:0] d);
    int waited = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && waited < 200) begin
      @(negedge vga_clk);
      waited++;
    end
    if (!wr_ready) chk("push_timeout", 32'(wr_ready), 32'd1);
    else exp_wr_q.push_back({a, d});
    @(negedge vga_clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_level0();
    int n = 0;
    while (fifo_level != 3'd0 && n < 50) begin
      @(negedge vga_clk);
      n++;
    end
    chk("drain_done", 32'(fifo_level), 32'd0);
    @(negedge vga_clk);
  endtask

  // monitor: pops expected writes on mem_we, expected pixels three edges after a read
  initial begin
    logic       rdn_smp;
    logic       rst_smp;
    logic [2:0] rh;
    logic [30:0] ew;
    logic [11:0] ep;
    rh = 3'b000;
    forever begin
      @(posedge vga_clk);
      rdn_smp = rdn;
      rst_smp = rst;
      if (!rst_smp && !rdn_smp) exp_rd_q.push_back({row_addr[1:0], col_addr});
      #1;
      if (rst_smp || rst) begin
        rh = 3'b000;
        exp_rd_q.delete();
      end else begin
        rh = {rh[1:0], !rdn_smp};
        if (mem_we) begin
          if (exp_wr_q.size() == 0) begin
            chk("wr_unexpected", 32'(mem_we), 32'd0);
          end else begin
            ew = exp_wr_q.pop_front();
            chk("wr_order", 32'({mem_addr, mem_wdata}), 32'(ew));
          end
        end
        if (rh[2]) begin
          if (exp_rd_q.size() == 0) begin
            chk("rd_missing", 32'd0, 32'd1);
          end else begin
            ep = exp_rd_q.pop_front();
            chk("pix_read", 32'(pix_data), 32'(ep));
          end
        end else begin
          chk("pix_blank", 32'(pix_data), 32'h000);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    summary();
    $finish;
  end

  initial begin
    rst = 1'b1; rst_s = 1'b1; rdn = 1'b1; row_addr = '0; col_addr = '0;
    wr_valid = 1'b1; wr_addr = '0; wr_data = '0;

    // reset state
    #10;
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_pix", 32'(pix_data), 32'h000);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    #20;
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge vga_clk);
    chk("post_rst_ready", 32'(wr_ready), 32'd1);

    // display read row 5 col 7
    rdn = 1'b0; row_addr = 9'd5; col_addr = 10'd7;
    @(negedge vga_clk);
    chk("rd_mem_addr", 32'(mem_addr), 32'h01407);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    rdn = 1'b1;
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk("rd_pix_407", 32'(pix_data), 32'h407);
    @(negedge vga_clk);
    chk("rd_pix_blank", 32'(pix_data), 32'h000);

    // blanking drain of three writes
    push_wr(19'h00010, 12'hF00);
    chk("drain_we0", 32'(mem_we), 32'd0);
    chk("drain_lvl0", 32'(fifo_level), 32'd1);
    push_wr(19'h00011, 12'h0F0);
    chk("drain_we1", 32'(mem_we), 32'd1);
    chk("drain_addr1", 32'(mem_addr), 32'h00010);
    chk("drain_data1", 32'(mem_wdata), 32'hF00);
    chk("drain_lvl1", 32'(fifo_level), 32'd1);
    push_wr(19'h00012, 12'h00F);
    chk("drain_addr2", 32'(mem_addr), 32'h00011);
    chk("drain_lvl2", 32'(fifo_level), 32'd1);
    @(negedge vga_clk);
    chk("drain_addr3", 32'(mem_addr), 32'h00012);
    chk("drain_data3", 32'(mem_wdata), 32'h00F);
    chk("drain_lvl3", 32'(fifo_level), 32'd0);
    @(negedge vga_clk);
    chk("drain_idle_we", 32'(mem_we), 32'd0);

    // display priority with FIFO filling up
    fork
      begin
        rdn = 1'b0;
        for (int i = 0; i < 10; i++) begin
          row_addr = 9'(i + 1);
          col_addr = 10'(100 + i);
          @(negedge vga_clk);
        end
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_we", 32'(mem_we), 32'd0);
        chk("full_stall", 32'(stall_cnt), 32'd9);
        rdn = 1'b1;
      end
      begin
        for (int k = 0; k < 6; k++) push_wr(19'(32 + k), 12'(256 + k));
      end
    join
    wait_level0();
    chk("full_stall_hold", 32'(stall_cnt), 32'd9);
    chk("full_ready_back", 32'(wr_ready), 32'd1);

    // simultaneous push and pop at level 2
    rdn = 1'b0;
    push_wr(19'h00030, 12'hAAA);
    push_wr(19'h00031, 12'hBBB);
    chk("pp_level_pre", 32'(fifo_level), 32'd2);
    chk("pp_stall", 32'(stall_cnt), 32'd10);
    rdn = 1'b1;
    push_wr(19'h00032, 12'hCCC);
    chk("pp_level", 32'(fifo_level), 32'd2);
    chk("pp_we", 32'(mem_we), 32'd1);
    chk("pp_addr", 32'(mem_addr), 32'h00030);
    chk("pp_data", 32'(mem_wdata), 32'hAAA);
    wait_level0();

    // stall counter saturation on the narrow instance
    rst_s = 1'b0;
    repeat (15) @(negedge vga_clk);
    chk("sat_14", 32'(stall_s), 32'd14);
    @(negedge vga_clk);
    chk("sat_15", 32'(stall_s), 32'd15);
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      chk("sat_hold", 32'(stall_s), 32'd15);
    end

    // reset with three writes buffered
    rdn = 1'b0;
    push_wr(19'h00040, 12'h111);
    push_wr(19'h00041, 12'h222);
    push_wr(19'h00042, 12'h333);
    chk("mid_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    exp_wr_q.delete();
    #1;
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_ready", 32'(wr_ready), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    chk("mid_rst_pix", 32'(pix_data), 32'h000);
    rdn = 1'b1;
    @(negedge vga_clk);
    @(negedge vga_clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge vga_clk);
      chk("mid_no_we", 32'(mem_we), 32'd0);
      chk("mid_lvl0", 32'(fifo_level), 32'd0);
    end
    chk("mid_ready", 32'(wr_ready), 32'd1);

    chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
